renkon_demux_input: RTL and testbench
=====================================

Name: renkon_demux_input

Overview:
Input-side distributor for the renkon core array; the write-side counterpart of the output mux that reads core results back.
- Accepts one serial stream of DWIDTH words with a valid/ready handshake.
- Scatters the words core-major into the per-core local memories: a 1-based core selector, a word address and registered data.
- Sits between the DMA/input FIFO and the RENKON_CORE core buffers; sequenced by the top controller through start/done.

Parameters:
- DWIDTH, 16 (from renkon.svh): data word width, signed.
- RENKON_CORE, 8 (from renkon.svh): number of cores.
- RENKON_CORELOG, 3 (from renkon.svh): log2(RENKON_CORE).
- AWIDTH, 10: core memory address width; also the width of the per-core word count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a transfer and latches total
- total  in  AWIDTH  words per core; sampled only when start is accepted
- in_valid  in  1  input word valid
- in_data  in  DWIDTH signed  input word
- in_ready  out  1  word accepted when in_valid && in_ready
- input_we  out  RENKON_CORELOG+1  1-based core select (k = core k-1); 0 means no write
- mem_addr  out  AWIDTH  word address within the selected core
- out_data  out  DWIDTH signed  write data
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, counters 0. in_ready, input_we, mem_addr, out_data, busy and done are all 0 from that edge on. Reset mid-transfer aborts the transfer; there is no partial-done pulse.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 latches total, clears word_cnt and core_cnt. Next state is RUN if total!=0, else FIN.
  - RUN: in_ready=1 (registered; high for every cycle spent in RUN).
  - An accept increments word_cnt. When word_cnt==total-1 it wraps to 0 and core_cnt increments.
  - The accept with word_cnt==total-1 and core_cnt==RENKON_CORE-1 moves the FSM to FIN.
  - FIN: lasts exactly one cycle; then IDLE.
- Write path: one-cycle latency. An accept at edge t produces, valid for the cycle after t:
  - input_we = core_cnt+1
  - mem_addr = word_cnt
  - out_data = in_data
  In cycles with no accept, input_we=0; mem_addr and out_data hold their previous values.
- Status outputs:
  - done=1 exactly in the FIN cycle. This is the same cycle as the final write, or the cycle after start when total==0.
  - busy = (state != IDLE) && !done.
- Backpressure: in_valid gaps stall the counters; addresses remain contiguous per core.
- start outside IDLE is ignored; total changes outside IDLE are ignored.
- in_valid in IDLE or FIN: not accepted, no write.
- Total words per transfer = total*RENKON_CORE. Counters never exceed total-1 and RENKON_CORE-1.

Optional Feature:
RENKON_DEMUX_BROADCAST_EN
- Defined:
  - Adds input port broadcast (1 bit), latched with start.
  - When latched high, only total words are accepted (core_cnt stays 0).
  - Each write drives input_we = all-ones, 2**(RENKON_CORELOG+1)-1. Cores decode this as write-all.
  - FIN follows the accept with word_cnt==total-1.
- Undefined: the port is absent and the all-ones code is never emitted.

Decomposition:
- renkon.svh / shared package gains:
  - typedef enum for the state: IDLE, RUN, FIN
  - constant RENKON_SEL_BCAST = 2**(RENKON_CORELOG+1)-1
  - constant RENKON_SEL_NONE = 0
- Select-code constants are shared with renkon_mux_output users.
- No sub-module; two counters plus the FSM stay in one module.

Test Plan:
- Nominal: total=4, 32 words in_data=0..31 with in_valid held 1 → input_we 1,1,1,1,2,…,8; mem_addr 0..3 repeating; out_data 0..31; done coincides with write of 31; in_ready low after it.
- Backpressure: total=3, in_valid pattern 1,0,0,1,1,0,1… → no write on gap cycles; core1 gets addr 0,1,2 contiguous; 24 writes total; single done pulse.
- Zero length: start with total=0 → no writes; done=1 the cycle after start; busy never high; in_ready stays 0.
- Start while busy: second start with total=7 mid-run of total=2 → ignored; exactly 16 writes; total latched at 2 throughout.
- Reset mid-run: rst=1 after 10 accepts of total=4 → next cycle all outputs 0, state IDLE; a subsequent start with total=1 gives 8 clean writes, addr 0.
- Broadcast (RENKON_DEMUX_BROADCAST_EN, broadcast=1, total=5): data 10..14 → input_we=15 (CORELOG=3), mem_addr 0..4; done with 5th write; a 6th valid word is not accepted.

Source files
------------

// File: rtl/renkon_demux_input_pkg.sv
// Shared definitions for the renkon input distributor: default geometry, FSM
// state encoding and the core-select codes also used by renkon_mux_output users.
package renkon_demux_input_pkg;

    localparam int DEF_DWIDTH      = 16;
    localparam int DEF_CORE        = 8;
    localparam int DEF_CORELOG     = 3;
    localparam int DEF_AWIDTH      = 10;

    // Select codes: 0 is "no write", all-ones is "write every core".
    localparam int RENKON_SEL_NONE  = 0;
    localparam int RENKON_SEL_BCAST = (2 ** (DEF_CORELOG + 1)) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } renkon_demux_state_e;

    // 1-based select code for a 0-based core index.
    function automatic int core_sel(input int core_idx);
        return core_idx + 1;
    endfunction

endpackage

// File: rtl/renkon_demux_input.sv
// Serial-to-core scatter: writes total words into each core, core-major.
// Optional broadcast mode via RENKON_DEMUX_BROADCAST_EN.
module renkon_demux_input
    import renkon_demux_input_pkg::*;
#(
    parameter int DWIDTH         = DEF_DWIDTH,
    parameter int RENKON_CORE    = DEF_CORE,
    parameter int RENKON_CORELOG = DEF_CORELOG,
    parameter int AWIDTH         = DEF_AWIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [AWIDTH-1:0]           total,
    input  logic                        in_valid,
    input  logic signed [DWIDTH-1:0]    in_data,
    output logic                        in_ready,
    output logic [RENKON_CORELOG:0]     input_we,
    output logic [AWIDTH-1:0]           mem_addr,
    output logic signed [DWIDTH-1:0]    out_data,
    output logic                        busy,
`ifdef RENKON_DEMUX_BROADCAST_EN
    input  logic                        broadcast,
`endif
    output logic                        done
);

    localparam int SELW = RENKON_CORELOG + 1;
    localparam logic [SELW-1:0] SEL_NONE = SELW'(RENKON_SEL_NONE);
    localparam logic [RENKON_CORELOG-1:0] LAST_CORE = RENKON_CORELOG'(RENKON_CORE - 1);

    renkon_demux_state_e           state_r;
    renkon_demux_state_e           state_nxt_s;
    logic [AWIDTH-1:0]             total_r;
    logic [AWIDTH-1:0]             word_cnt_r;
    logic [RENKON_CORELOG-1:0]     core_cnt_r;
    logic                          in_ready_r;
    logic [SELW-1:0]               input_we_r;
    logic [AWIDTH-1:0]             mem_addr_r;
    logic signed [DWIDTH-1:0]      out_data_r;
    logic                          busy_r;
    logic                          done_r;

    logic                          accept_s;
    logic                          last_word_s;
    logic                          last_core_s;
    logic [SELW-1:0]               wr_sel_s;

`ifdef RENKON_DEMUX_BROADCAST_EN
    localparam logic [SELW-1:0] SEL_BCAST = {SELW{1'b1}};
    logic                          bcast_r;
`endif

    assign accept_s    = in_valid && in_ready_r && (state_r == ST_RUN);
    assign last_word_s = (word_cnt_r == (total_r - {{(AWIDTH-1){1'b0}}, 1'b1}));

    // Last-core detection; in broadcast mode a single pass over total words ends the transfer.
    always_comb begin
        last_core_s = (core_cnt_r == LAST_CORE);
`ifdef RENKON_DEMUX_BROADCAST_EN
        if (bcast_r) begin
            last_core_s = 1'b1;
        end else begin
            last_core_s = (core_cnt_r == LAST_CORE);
        end
`endif
    end

    // Select code for the word being accepted this cycle.
    always_comb begin
        wr_sel_s = SELW'(core_sel(int'(core_cnt_r)));
`ifdef RENKON_DEMUX_BROADCAST_EN
        if (bcast_r) begin
            wr_sel_s = SEL_BCAST;
        end else begin
            wr_sel_s = SELW'(core_sel(int'(core_cnt_r)));
        end
`endif
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (total == {AWIDTH{1'b0}}) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_word_s && last_core_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, latched transfer length and the word/core counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            total_r    <= {AWIDTH{1'b0}};
            word_cnt_r <= {AWIDTH{1'b0}};
            core_cnt_r <= {RENKON_CORELOG{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        total_r    <= total;
                        word_cnt_r <= {AWIDTH{1'b0}};
                        core_cnt_r <= {RENKON_CORELOG{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (last_word_s) begin
                            word_cnt_r <= {AWIDTH{1'b0}};
                            // Wrap rather than overflow on the final accept.
                            if (last_core_s) begin
                                core_cnt_r <= {RENKON_CORELOG{1'b0}};
                            end else begin
                                core_cnt_r <= core_cnt_r + {{(RENKON_CORELOG-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            word_cnt_r <= word_cnt_r + {{(AWIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RENKON_DEMUX_BROADCAST_EN
    // Broadcast mode is captured together with total.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            bcast_r <= broadcast;
        end
    end
`endif

    // Registered write port: one-cycle latency, address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            input_we_r <= SEL_NONE;
            mem_addr_r <= {AWIDTH{1'b0}};
            out_data_r <= {DWIDTH{1'b0}};
        end else if (accept_s) begin
            input_we_r <= wr_sel_s;
            mem_addr_r <= word_cnt_r;
            out_data_r <= in_data;
        end else begin
            input_we_r <= SEL_NONE;
        end
    end

    // Status flags follow the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == ST_RUN);
            busy_r     <= (state_nxt_s == ST_RUN);
            done_r     <= (state_nxt_s == ST_FIN);
        end
    end

    assign in_ready = in_ready_r;
    assign input_we = input_we_r;
    assign mem_addr = mem_addr_r;
    assign out_data = out_data_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_renkon_demux_input.sv
// Directed bench for renkon_demux_input; the broadcast case runs only when
// RENKON_DEMUX_BROADCAST_EN is defined.
module tb_renkon_demux_input;
    import renkon_demux_input_pkg::*;

    localparam int DW = 16;
    localparam int NC = 8;
    localparam int CL = 3;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start;
    logic [AW-1:0]        total;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic [CL:0]          input_we;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic                 done;
`ifdef RENKON_DEMUX_BROADCAST_EN
    logic                 broadcast;
`endif

    int compared   = 0;
    int mismatched = 0;

    renkon_demux_input #(
        .DWIDTH(DW), .RENKON_CORE(NC), .RENKON_CORELOG(CL), .AWIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .total(total),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .input_we(input_we), .mem_addr(mem_addr), .out_data(out_data),
        .busy(busy),
`ifdef RENKON_DEMUX_BROADCAST_EN
        .broadcast(broadcast),
`endif
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int we, input int addr, input int data);
        chk({tag, "_we"}, 32'(input_we), 32'(we));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(input_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int widx;
        int ndone;
        int last_addr;
        int last_data;

        rst = 1'b1; start = 1'b0; total = '0; in_valid = 1'b0; in_data = '0;
`ifdef RENKON_DEMUX_BROADCAST_EN
        broadcast = 1'b0;
`endif
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Nominal: total=4, 32 words.
        start = 1'b1; total = 10'd4; in_valid = 1'b1; in_data = 16'sd99;
        tick();
        chk("nom_start_busy", 32'(busy), 32'd1);
        chk("nom_start_ready", 32'(in_ready), 32'd1);
        chk("nom_idle_no_write", 32'(input_we), 32'd0);
        start = 1'b0; total = 10'd0;
        for (int i = 0; i < 32; i++) begin
            in_data = DW'(i);
            tick();
            check_wr("nom", i / 4 + 1, i % 4, i);
            chk("nom_done", 32'(done), 32'(i == 31));
            chk("nom_ready", 32'(in_ready), 32'(i != 31));
            chk("nom_busy", 32'(busy), 32'(i != 31));
        end
        in_valid = 1'b0;
        tick();
        chk("nom_after_done", 32'(done), 32'd0);
        chk("nom_after_we", 32'(input_we), 32'd0);
        chk("nom_hold_addr", 32'(mem_addr), 32'd3);
        chk("nom_hold_data", 32'(out_data), 32'd31);
        chk("nom_after_ready", 32'(in_ready), 32'd0);

        // Backpressure: total=3, valid pattern 1,0,0,1,1,0 repeating.
        start = 1'b1; total = 10'd3;
        tick();
        start = 1'b0;
        widx = 0; ndone = 0; last_addr = 0; last_data = 0;
        for (int c = 0; c < 200 && widx < 24; c++) begin
            in_valid = pat[c % 6];
            in_data  = DW'(100 + widx);
            tick();
            if (pat[c % 6]) begin
                check_wr("bp", widx / 3 + 1, widx % 3, 100 + widx);
                last_addr = widx % 3;
                last_data = 100 + widx;
                widx++;
                chk("bp_done", 32'(done), 32'(widx == 24));
            end else begin
                chk("bp_gap_we", 32'(input_we), 32'd0);
                chk("bp_gap_addr", 32'(mem_addr), 32'(last_addr));
                chk("bp_gap_data", 32'(out_data), 32'(last_data));
            end
            ndone += int'(done);
        end
        chk("bp_writes", 32'(widx), 32'd24);
        in_valid = 1'b1;
        tick();
        ndone += int'(done);
        chk("bp_post_we", 32'(input_we), 32'd0);
        chk("bp_post_ready", 32'(in_ready), 32'd0);
        chk("bp_done_count", 32'(ndone), 32'd1);

        // Zero length.
        start = 1'b1; total = 10'd0; in_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_ready", 32'(in_ready), 32'd0);
        chk("zero_we", 32'(input_we), 32'd0);
        tick();
        chk("zero_done2", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);
        chk("zero_ready2", 32'(in_ready), 32'd0);
        chk("zero_we2", 32'(input_we), 32'd0);
        in_valid = 1'b0;

        // Start while busy: the second start/total must be ignored.
        start = 1'b1; total = 10'd2;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = DW'(200 + i);
            if (i == 5) begin
                start = 1'b1; total = 10'd7;
            end else begin
                start = 1'b0;
            end
            tick();
            check_wr("sb", i / 2 + 1, i % 2, 200 + i);
            chk("sb_done", 32'(done), 32'(i == 15));
        end
        start = 1'b0; in_valid = 1'b0;
        tick();
        chk("sb_post_we", 32'(input_we), 32'd0);
        chk("sb_post_done", 32'(done), 32'd0);

        // Reset mid-run, then a clean total=1 transfer.
        start = 1'b1; total = 10'd4;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = DW'(50 + i);
            tick();
            check_wr("rm", i / 4 + 1, i % 4, 50 + i);
        end
        rst = 1'b1;
        tick();
        check_idle_outputs("rm_reset");
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rm_idle_ready", 32'(in_ready), 32'd0);
        chk("rm_idle_done", 32'(done), 32'd0);
        start = 1'b1; total = 10'd1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(300 + i);
            tick();
            check_wr("rm2", i + 1, 0, 300 + i);
            chk("rm2_done", 32'(done), 32'(i == 7));
        end
        in_valid = 1'b0;
        tick();
        chk("rm2_post_we", 32'(input_we), 32'd0);

`ifdef RENKON_DEMUX_BROADCAST_EN
        // Broadcast: total words, all-ones select.
        broadcast = 1'b1; start = 1'b1; total = 10'd5;
        tick();
        start = 1'b0; broadcast = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'(10 + i);
            tick();
            check_wr("bc", (1 << (CL + 1)) - 1, i, 10 + i);
            chk("bc_done", 32'(done), 32'(i == 4));
        end
        in_data = DW'(15);
        tick();
        chk("bc_extra_we", 32'(input_we), 32'd0);
        chk("bc_extra_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
